// File: rtl/lbp_pkg.sv
// Shared constants, FSM state type and 3x3 window position table for the LBP engine.
package lbp_pkg;

  localparam int LBP_IMG_W  = 128;
  localparam int LBP_ADDR_W = 14;
  localparam int LBP_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    CALC,
    WRITE,
    NEXT,
    DONE
  } state_t;

  // Window position: r/c of 0,1,2 stand for row/col offsets -1,0,+1 around the center.
  typedef struct packed {
    logic [1:0] r;
    logic [1:0] c;
  } win_pos_t;

  function automatic win_pos_t win_pos(input logic [3:0] slot);
    win_pos_t p;
    p = '{2'd1, 2'd1};
    case (slot)
      4'd0:    p = '{2'd0, 2'd0};
      4'd1:    p = '{2'd0, 2'd1};
      4'd2:    p = '{2'd0, 2'd2};
      4'd3:    p = '{2'd1, 2'd0};
      4'd4:    p = '{2'd1, 2'd1};
      4'd5:    p = '{2'd1, 2'd2};
      4'd6:    p = '{2'd2, 2'd0};
      4'd7:    p = '{2'd2, 2'd1};
      4'd8:    p = '{2'd2, 2'd2};
      default: p = '{2'd1, 2'd1};
    endcase
    return p;
  endfunction

  // A partial fetch only loads the right column: slots 2, 5, 8.
  function automatic logic [3:0] fetch_slot(input logic [3:0] idx, input logic full);
    return full ? idx : 4'(idx * 4'd3 + 4'd2);
  endfunction

  function automatic logic [3:0] fetch_count(input logic full);
    return full ? 4'd9 : 4'd3;
  endfunction

endpackage

// File: rtl/lbp_code.sv
// Combinational LBP code: bit k is set when neighbor k is >= the center pixel.
module lbp_code
  import lbp_pkg::*;
#(
  parameter int DATA_W = LBP_DATA_W
) (
  input  logic [7:0][DATA_W-1:0] nb,
  input  logic [DATA_W-1:0]      center,
  output logic [7:0]             code
);

  always_comb begin
    // NOTE: default every always_comb output first so no path can infer a latch.
    code = '0;
    for (int k = 0; k < 8; k++) begin
      code[k] = (nb[k] >= center);
    end
  end

endmodule

// File: rtl/lbp.sv
// LBP engine: scans interior pixels, fetches the 3x3 window, writes one code per center.
// Build option LBP_WINDOW_REUSE_EN keeps the window between adjacent centers of a row.
module lbp
  import lbp_pkg::*;
#(
  parameter int IMG_W  = LBP_IMG_W,
  parameter int ADDR_W = LBP_ADDR_W,
  parameter int DATA_W = LBP_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              gray_ready,
  output logic              gray_req,
  output logic [ADDR_W-1:0] gray_addr,
  input  logic [DATA_W-1:0] gray_data,
  output logic              lbp_valid,
  output logic [ADDR_W-1:0] lbp_addr,
  output logic [DATA_W-1:0] lbp_data,
  output logic              finish
);

  localparam int            CW    = ADDR_W / 2;
  localparam logic [CW-1:0] FIRST = CW'(1);
  localparam logic [CW-1:0] LAST  = CW'(IMG_W - 2);

  state_t                      state, next_state;
  logic [CW-1:0]               row, col;
  logic [3:0]                  issue_cnt, cap_cnt, fetch_n;
  logic                        full_fetch, fetch_done, last_center, issue_en;
  win_pos_t                    pos_i, pos_c;
  logic [CW-1:0]               issue_row, issue_col;
  logic [2:0][2:0][DATA_W-1:0] win;
  logic [7:0][DATA_W-1:0]      nb;
  logic [7:0]                  code;

`ifdef LBP_WINDOW_REUSE_EN
  assign full_fetch = (col == FIRST);
`else
  assign full_fetch = 1'b1;
`endif

  assign fetch_n     = fetch_count(full_fetch);
  assign pos_i       = win_pos(fetch_slot(issue_cnt, full_fetch));
  assign pos_c       = win_pos(fetch_slot(cap_cnt, full_fetch));
  assign issue_row   = row + CW'(pos_i.r) - FIRST;
  assign issue_col   = col + CW'(pos_i.c) - FIRST;
  assign last_center = (row == LAST) && (col == LAST);
  // The read returning on this edge may be the last one of the window.
  assign fetch_done  = (cap_cnt == fetch_n) || (gray_req && (cap_cnt == fetch_n - 4'd1));

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (gray_ready) next_state = FETCH;
      FETCH:   if (gray_ready && fetch_done) next_state = CALC;
      CALC:    next_state = WRITE;
      WRITE:   next_state = NEXT;
      NEXT:    next_state = last_center ? DONE : FETCH;
      DONE:    next_state = DONE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    issue_en  = 1'b0;
    lbp_valid = 1'b0;
    finish    = 1'b0;
    case (state)
      FETCH:   issue_en  = gray_ready && (issue_cnt < fetch_n);
      WRITE:   lbp_valid = 1'b1;
      DONE:    finish    = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row       <= FIRST;
      col       <= FIRST;
      issue_cnt <= '0;
      cap_cnt   <= '0;
      gray_req  <= 1'b0;
      gray_addr <= '0;
      lbp_addr  <= '0;
      lbp_data  <= '0;
    end else begin
      gray_req <= issue_en;
      if (issue_en) begin
        gray_addr <= {issue_row, issue_col};
        issue_cnt <= issue_cnt + 4'd1;
      end
      if (gray_req) cap_cnt <= cap_cnt + 4'd1;
      if (state == CALC) begin
        lbp_addr <= {row, col};
        lbp_data <= code;
      end
      if (state == NEXT) begin
        issue_cnt <= '0;
        cap_cnt   <= '0;
        if (col == LAST) begin
          col <= FIRST;
          row <= row + CW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
    end
  end

  // NOTE: the window is not reset; CALC only reads slots loaded since the row started.
  always_ff @(posedge clk) begin
    if (gray_req) begin
      win[pos_c.r][pos_c.c] <= gray_data;
`ifdef LBP_WINDOW_REUSE_EN
    end else if (state == NEXT && col != LAST) begin
      for (int r = 0; r < 3; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= win[r][2];
      end
`endif
    end
  end

  assign nb = {win[2][2], win[2][1], win[2][0], win[1][2],
               win[1][0], win[0][2], win[0][1], win[0][0]};

  lbp_code #(.DATA_W(DATA_W)) u_code (
    .nb     (nb),
    .center (win[1][1]),
    .code   (code)
  );

endmodule

// File: tb/tb_lbp.sv
// Self-checking bench for lbp on a 16x16 frame: host RAM models, directed images, stall and reset cases.
module tb_lbp;

  localparam int TW     = 16;
  localparam int TAW    = 8;
  localparam int TCW    = 4;
  localparam int DW     = 8;
  localparam int N_PIX  = TW * TW;
  localparam int N_CTR  = (TW - 2) * (TW - 2);
  localparam int BUDGET = 10000;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           gray_ready = 1'b0;
  logic           gray_req;
  logic [TAW-1:0] gray_addr;
  logic [DW-1:0]  gray_data = '0;
  logic           lbp_valid;
  logic [TAW-1:0] lbp_addr;
  logic [DW-1:0]  lbp_data;
  logic           finish;

  always #5 clk = ~clk;

  lbp #(.IMG_W(TW), .ADDR_W(TAW), .DATA_W(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .gray_ready (gray_ready),
    .gray_req   (gray_req),
    .gray_addr  (gray_addr),
    .gray_data  (gray_data),
    .lbp_valid  (lbp_valid),
    .lbp_addr   (lbp_addr),
    .lbp_data   (lbp_data),
    .finish     (finish)
  );

  logic [7:0] gray_mem [N_PIX];
  logic [7:0] res_mem  [N_PIX];
  int write_cnt, order_err, post_done_err, exp_r, exp_c;
  int n_checks = 0;
  int n_fail   = 0;
  int dr [8] = '{-1, -1, -1, 0, 0, 1, 1, 1};
  int dc [8] = '{-1, 0, 1, -1, 1, -1, 0, 1};

  typedef struct {
    int         pat;
    int         r;
    int         c;
    logic [7:0] code;
  } vec_t;
  vec_t vecs [17];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Host side: gray RAM answers on negedge, result RAM samples the write strobe on negedge.
  always @(negedge clk) begin
    gray_data = gray_mem[gray_addr];
    if (lbp_valid) begin
      res_mem[lbp_addr] = lbp_data;
      write_cnt++;
      if (lbp_addr !== TAW'({exp_r[TCW-1:0], exp_c[TCW-1:0]})) order_err++;
      if (exp_c == TW - 2) begin
        exp_c = 1;
        exp_r++;
      end else begin
        exp_c++;
      end
    end
    if (finish && (gray_req || lbp_valid)) post_done_err++;
  end

  function automatic logic [7:0] ref_code(input int r, input int c);
    logic [7:0] code;
    logic [7:0] gc;
    gc = gray_mem[r * TW + c];
    for (int k = 0; k < 8; k++)
      code[k] = (gray_mem[(r + dr[k]) * TW + (c + dc[k])] >= gc);
    return code;
  endfunction

  function automatic int frame_errors();
    int errs = 0;
    for (int r = 0; r < TW; r++)
      for (int c = 0; c < TW; c++) begin
        if (r == 0 || c == 0 || r == TW - 1 || c == TW - 1) begin
          if (res_mem[r * TW + c] !== 8'h00) errs++;
        end else if (res_mem[r * TW + c] !== ref_code(r, c)) begin
          errs++;
        end
      end
    return errs;
  endfunction

  task automatic load_image(input int p);
    for (int r = 0; r < TW; r++)
      for (int c = 0; c < TW; c++)
        case (p)
          0:       gray_mem[r * TW + c] = 8'h55;
          1:       gray_mem[r * TW + c] = 8'(c);
          2:       gray_mem[r * TW + c] = 8'(r);
          3:       gray_mem[r * TW + c] = 8'(TW - 1 - r);
          4:       gray_mem[r * TW + c] = (r == 5 && c == 5) ? 8'hFF : 8'h00;
          default: gray_mem[r * TW + c] = 8'($urandom_range(0, 255));
        endcase
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset      = 1'b0;
    gray_ready = 1'b0;
    for (int i = 0; i < N_PIX; i++) res_mem[i] = 8'h00;
    write_cnt     = 0;
    order_err     = 0;
    post_done_err = 0;
    exp_r         = 1;
    exp_c         = 1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic finish_frame(input string tag);
    int cyc = 0;
    while (!finish && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
    end
    check($sformatf("%s_finish", tag), 32'(finish), 32'd1);
    repeat (20) @(negedge clk);
    check($sformatf("%s_quiet_after_done", tag), 32'(post_done_err), 32'd0);
    check($sformatf("%s_write_count", tag), 32'(write_cnt), 32'(N_CTR));
    check($sformatf("%s_write_order", tag), 32'(order_err), 32'd0);
    check($sformatf("%s_frame_contents", tag), 32'(frame_errors()), 32'd0);
  endtask

  initial begin
    int stall_req;
    int cyc;

    vecs = '{'{0, 1, 1, 8'hFF}, '{0, 14, 14, 8'hFF}, '{0, 0, 0, 8'h00}, '{0, 15, 7, 8'h00},
             '{0, 7, 15, 8'h00}, '{1, 1, 1, 8'hD6}, '{1, 7, 9, 8'hD6}, '{1, 14, 14, 8'hD6},
             '{2, 1, 1, 8'hF8}, '{2, 14, 3, 8'hF8}, '{3, 2, 2, 8'h1F}, '{3, 14, 14, 8'h1F},
             '{4, 5, 5, 8'h00}, '{4, 4, 4, 8'hFF}, '{4, 6, 6, 8'hFF}, '{4, 5, 6, 8'hFF},
             '{4, 10, 10, 8'hFF}};
    for (int i = 0; i < N_PIX; i++) gray_mem[i] = 8'h00;

    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 32'({gray_req, lbp_valid, finish, gray_addr, lbp_addr, lbp_data}), 32'd0);

    // IDLE must not read while the host image is unavailable.
    do_reset();
    stall_req = 0;
    repeat (10) begin
      @(negedge clk);
      stall_req += int'(gray_req);
    end
    check("idle_no_req", 32'(stall_req), 32'd0);

    // Directed images with hand-computed codes at chosen positions.
    for (int p = 0; p < 5; p++) begin
      load_image(p);
      do_reset();
      @(negedge clk) gray_ready = 1'b1;
      finish_frame($sformatf("pat%0d", p));
      foreach (vecs[i])
        if (vecs[i].pat == p)
          check($sformatf("pat%0d_code_r%0d_c%0d", p, vecs[i].r, vecs[i].c),
                32'(res_mem[vecs[i].r * TW + vecs[i].c]), 32'(vecs[i].code));
    end

    load_image(5);
    do_reset();
    @(negedge clk) gray_ready = 1'b1;
    finish_frame("random");

    // Ten-cycle gray_ready stall in the middle of a window fetch.
    load_image(5);
    do_reset();
    @(negedge clk) gray_ready = 1'b1;
    cyc = 0;
    while ((write_cnt < 20 || !gray_req) && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
    end
    gray_ready = 1'b0;
    stall_req  = 0;
    repeat (10) begin
      @(negedge clk);
      stall_req += int'(gray_req);
    end
    check("stall_no_req", 32'(stall_req), 32'd0);
    gray_ready = 1'b1;
    finish_frame("stall");

    // Asynchronous reset mid-frame, then a complete rerun.
    load_image(5);
    do_reset();
    @(negedge clk) gray_ready = 1'b1;
    repeat (700) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("midframe_reset_outputs", 32'({gray_req, lbp_valid, finish, gray_addr, lbp_addr, lbp_data}), 32'd0);
    do_reset();
    @(negedge clk) gray_ready = 1'b1;
    finish_frame("rerun");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
